// File: rtl/mc_lsm_scheduler_if.sv
// Control, path-memory and pricing-core signals of the LSM scheduler.
// master is the scheduler's view; slave is the view of whatever drives it.
interface mc_lsm_scheduler_if #(
  parameter int unsigned W  = 12,
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 3
);
  logic          start;
  logic          abort;
  logic [W-1:0]  k_in;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rdata;
  logic [W-1:0]  core_path;
  logic          core_path_vld;
  logic [W-1:0]  core_k;
  logic          core_day_done;
  logic [W-1:0]  core_price;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  price;
  logic [DW-1:0] day;

  modport master (
    input  start, abort, k_in, mem_rdata, core_day_done, core_price,
    output mem_rd, mem_addr, core_path, core_path_vld, core_k,
           busy, done, err, price, day
  );

  modport slave (
    output start, abort, k_in, mem_rdata, core_day_done, core_price,
    input  mem_rd, mem_addr, core_path, core_path_vld, core_k,
           busy, done, err, price, day
  );
endinterface

// File: rtl/mc_lsm_scheduler.sv
// Backward-induction sequencer: streams path memory to the LSM core one value per
// cycle, from the last exercise day down to day 0, then captures the averaged price.
module mc_lsm_scheduler #(
  parameter int unsigned N       = 128,
  parameter int unsigned DAY     = 8,
  parameter int unsigned W       = 12,
  parameter int unsigned AW      = 10,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  mc_lsm_scheduler_if.master bus
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned DW = $clog2(DAY);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CORE, FINISH} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] day_q, day_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  core_k_q, core_k_d;
  logic [W-1:0]  price_q, price_d;
  logic [W-1:0]  path_q, path_d;
  logic          err_q, err_d;
  logic          vld_q, vld_d;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;

  assign mem_rd   = (state_q == ISSUE);
  assign mem_addr = {day_q, idx_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      day_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      core_k_q <= '0;
      price_q  <= '0;
      path_q   <= '0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      day_q    <= day_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      core_k_q <= core_k_d;
      price_q  <= price_d;
      path_q   <= path_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    day_d    = day_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    core_k_d = core_k_q;
    price_d  = price_q;
    err_d    = err_q;
    // Read data lands with the edge that ends the read cycle; abort drops it.
    vld_d    = mem_rd && !bus.abort;
    path_d   = mem_rd ? bus.mem_rdata : path_q;

    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            core_k_d = bus.k_in;
            day_d    = DW'(DAY - 1);
            idx_d    = '0;
            err_d    = 1'b0;
            state_d  = ISSUE;
          end
        end
        ISSUE: begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(N - 1)) begin
            cnt_d   = '0;
            state_d = WAIT_CORE;
          end
        end
        WAIT_CORE: begin
          if (bus.core_day_done) begin
            if (day_q == '0) begin
              price_d = bus.core_price;
              state_d = FINISH;
            end else begin
              day_d   = day_q - 1'b1;
              idx_d   = '0;
              state_d = ISSUE;
            end
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.mem_rd        = mem_rd;
  assign bus.mem_addr      = mem_addr;
  assign bus.core_path     = path_q;
  assign bus.core_path_vld = vld_q;
  assign bus.core_k        = core_k_q;
  assign bus.busy          = (state_q == ISSUE) || (state_q == WAIT_CORE);
  assign bus.done          = (state_q == FINISH);
  assign bus.err           = err_q;
  assign bus.price         = price_q;
  assign bus.day           = day_q;
endmodule

// File: tb/tb_mc_lsm_scheduler.sv
// Directed bench for mc_lsm_scheduler with N=4, DAY=2, TIMEOUT=8 and a path
// memory holding address+100.
module tb_mc_lsm_scheduler;
  localparam int unsigned N       = 4;
  localparam int unsigned DAY     = 2;
  localparam int unsigned W       = 12;
  localparam int unsigned AW      = 3;
  localparam int unsigned TIMEOUT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mc_lsm_scheduler_if #(.W(W), .AW(AW), .DW(1)) bus ();

  mc_lsm_scheduler #(
    .N(N), .DAY(DAY), .W(W), .AW(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  // Path memory: data for the address read in a cycle is present by that cycle's end.
  assign bus.mem_rdata = bus.mem_rd ? (W'(bus.mem_addr) + W'(100)) : 12'hEEE;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd"},    32'(bus.mem_rd), 0);
    check({tag, "_addr"},  32'(bus.mem_addr), 0);
    check({tag, "_path"},  32'(bus.core_path), 0);
    check({tag, "_vld"},   32'(bus.core_path_vld), 0);
    check({tag, "_k"},     32'(bus.core_k), 0);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_done"},  32'(bus.done), 0);
    check({tag, "_err"},   32'(bus.err), 0);
    check({tag, "_price"}, 32'(bus.price), 0);
    check({tag, "_day"},   32'(bus.day), 0);
  endtask

  initial begin
    int exp_rd, exp_vld;
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    bus.k_in          = '0;
    bus.core_day_done = 1'b0;
    bus.core_price    = '0;

    // Power-on reset
    #2 rst_n = 1'b0;
    #1 check_zero("rst");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Nominal two-day run; day_done 3 cycles after each day's last valid
    bus.k_in  = 12'd50;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      bus.core_day_done = (c == 8 || c == 16);
      bus.core_price    = (c == 16) ? 12'h07B : 12'h000;
      exp_rd  = ((c >= 1 && c <= 4) || (c >= 9 && c <= 12)) ? 1 : 0;
      exp_vld = ((c >= 2 && c <= 5) || (c >= 10 && c <= 13)) ? 1 : 0;
      check("nom_rd", 32'(bus.mem_rd), 32'(exp_rd));
      if (exp_rd != 0)
        check("nom_addr", 32'(bus.mem_addr), (c <= 4) ? 32'(4 + c - 1) : 32'(c - 9));
      check("nom_vld", 32'(bus.core_path_vld), 32'(exp_vld));
      if (exp_vld != 0)
        check("nom_path", 32'(bus.core_path), (c <= 5) ? 32'(104 + c - 2) : 32'(100 + c - 10));
      check("nom_busy",  32'(bus.busy),  (c <= 16) ? 1 : 0);
      check("nom_done",  32'(bus.done),  (c == 17) ? 1 : 0);
      check("nom_price", 32'(bus.price), (c >= 17) ? 32'h07B : 0);
      check("nom_day",   32'(bus.day),   (c <= 8) ? 1 : 0);
      check("nom_k",     32'(bus.core_k), 50);
      step();
    end
    bus.core_day_done = 1'b0;
    bus.core_price    = '0;

    // Strike latch, then abort at day 1 idx 2
    bus.k_in  = 12'h123;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.k_in  = 12'hFFF;
    for (int c = 1; c <= 3; c++) begin
      check("k_latch", 32'(bus.core_k), 32'h123);
      check("abt_addr", 32'(bus.mem_addr), 32'(4 + c - 1));
      check("abt_rd", 32'(bus.mem_rd), 1);
      if (c < 3) step();
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("abt_rd_off", 32'(bus.mem_rd), 0);
      check("abt_vld",    32'(bus.core_path_vld), 0);
      check("abt_busy",   32'(bus.busy), 0);
      check("abt_done",   32'(bus.done), 0);
      check("abt_price",  32'(bus.price), 32'h07B);
      check("abt_err",    32'(bus.err), 0);
      check("abt_k",      32'(bus.core_k), 32'h123);
      step();
    end

    // start and abort together in IDLE
    bus.k_in  = 12'h0AA;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("coll_busy", 32'(bus.busy), 0);
    check("coll_rd",   32'(bus.mem_rd), 0);
    check("coll_k",    32'(bus.core_k), 32'h123);
    step();
    check("coll_busy2", 32'(bus.busy), 0);

    // Run with early day_done, a stray start, and no handshake -> timeout
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      bus.core_day_done = (c == 2);
      bus.start         = (c == 3);
      bus.k_in          = (c == 3) ? 12'h555 : 12'h0AA;
      exp_rd  = (c <= 4) ? 1 : 0;
      exp_vld = (c >= 2 && c <= 5) ? 1 : 0;
      check("to_rd", 32'(bus.mem_rd), 32'(exp_rd));
      if (exp_rd != 0)
        check("to_addr", 32'(bus.mem_addr), 32'(4 + c - 1));
      check("to_vld", 32'(bus.core_path_vld), 32'(exp_vld));
      if (exp_vld != 0)
        check("to_path", 32'(bus.core_path), 32'(104 + c - 2));
      check("to_day",   32'(bus.day), 1);
      check("to_busy",  32'(bus.busy), (c <= 12) ? 1 : 0);
      check("to_err",   32'(bus.err),  (c >= 13) ? 1 : 0);
      check("to_done",  32'(bus.done), 0);
      check("to_k",     32'(bus.core_k), 32'h0AA);
      check("to_price", 32'(bus.price), 32'h07B);
      step();
    end
    bus.core_day_done = 1'b0;
    bus.start         = 1'b0;

    // Next start clears err
    bus.k_in  = 12'h0BB;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("clr_err",  32'(bus.err), 0);
    check("clr_busy", 32'(bus.busy), 1);
    check("clr_k",    32'(bus.core_k), 32'h0BB);
    step();
    step();
    check("pre_rst_vld",  32'(bus.core_path_vld), 1);
    check("pre_rst_path", 32'(bus.core_path), 105);

    // Asynchronous reset mid-run
    rst_n = 1'b0;
    #1 check_zero("mid_rst");
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_busy", 32'(bus.busy), 0);
    check("post_rst_vld",  32'(bus.core_path_vld), 0);
    check("post_rst_rd",   32'(bus.mem_rd), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
